pattern_sched: RTL
==================

// Module: pattern_sched
// PURPOSE
//  Scheduler for the testpattern generator on the pixel clock domain. Picks which pattern mode and
//  single-colour value the generator shows, stepping automatically every N frames or on a debounced
//  user button. Mode changes take effect only at frame start, so a frame is never torn. Sits between
//  the board button/pins and testpattern's mode/colour inputs; its VS is fed back from testpattern.
// PARAMETERS
//  FRAMES_PER_MODE  256     frames per mode in auto mode; legal range 1..65535
//  NUM_MODES        5       modes cycled 0..NUM_MODES-1; legal range 1..8 (3-bit mode)
//  DEBOUNCE_CYC     742500  cycles the synced button must be stable (10 ms at 74.25 MHz)
// PORTS
//  I_pxl_clk      in   1   pixel clock; the only clock
//  I_rst_n        in   1   asynchronous active-low reset; deassertion synchronous to I_pxl_clk upstream
//  I_vs           in   1   vertical sync from testpattern (O_vs)
//  I_vs_pol       in   1   VS polarity: 1 = active high, 0 = active low
//  I_auto_en      in   1   1 = auto-advance every FRAMES_PER_MODE frames, 0 = button only (sampled at frame start)
//  I_btn_n        in   1   asynchronous user button, active low, bouncy
//  O_mode         out  3   pattern mode to testpattern I_mode
//  O_single_r/g/b out  8   single-colour value to testpattern I_single_r/g/b (each 8 bits)
//  O_frame_cnt    out  16  frames shown in current mode; saturates at 16'hFFFF
//  O_mode_strobe  out  1   one-cycle pulse on the cycle O_mode/O_single_* change
// BEHAVIOUR
//  Reset values: O_mode=0, O_single=8'h00/8'hFF/8'h00 (green), O_frame_cnt=0, O_mode_strobe=0,
//   pal_idx=1, pending=0, frame-start edge register=1, synced button=1, debounced button=1.
//  Frame start (fs): one-cycle pulse on the rising edge of vs_a = I_vs XNOR I_vs_pol.
//   The edge register resets to 1, so VS active at reset release does not give a spurious fs.
//  Button: 2-FF sync (reset 1), then debounce. The stable level updates after DEBOUNCE_CYC
//   consecutive equal samples. press = 1->0 transition of the stable level. Release generates nothing.
//  State machine (2 states, chosen at each fs from I_auto_en):
//   S_AUTO: at fs, if O_frame_cnt == FRAMES_PER_MODE-1 or pending, then advance; else O_frame_cnt += 1.
//   S_MANUAL: at fs, if pending, then advance; else O_frame_cnt += 1 (saturating). No timed advance.
//   Transition S_AUTO<->S_MANUAL only at fs. O_frame_cnt is not cleared by a state change.
//  press sets pending. pending clears on an advance. Several presses within one frame give one advance.
//  fs and press in the same cycle: this fs advances (press is counted).
//  Timed expiry and pending at the same fs: exactly one advance.
//  Advance, updated on the fs cycle, visible the next cycle:
//   - O_mode = (O_mode == NUM_MODES-1) ? 0 : O_mode+1.
//   - O_frame_cnt = 0; O_mode_strobe = 1 for that cycle.
//   - On wrap to 0 only: pal_idx = pal_idx+1 mod 8, O_single = PALETTE[new pal_idx].
//  PALETTE (RGB) 0..7: 000000, 00FF00, FF0000, 0000FF, FFFFFF, FFFF00, 00FFFF, FF00FF.
//   The reset colour 00FF00 is PALETTE[1].
//  Latency: fs edge to new O_mode = 1 cycle after the VS edge is registered (2 clocks from the I_vs edge).
//  NUM_MODES=1: O_mode stays 0. An advance still resets O_frame_cnt, pulses the strobe and steps pal_idx.
//  Reset mid-frame or mid-debounce: everything returns to reset values at once. No partial advance survives.
//  No combinational path from any input to any output. All outputs are registered.
// STRUCTURE
//  Shared package pattern_pkg:
//   - state enum S_AUTO/S_MANUAL
//   - mode constants: TP_COLORBAR=0, TP_NET=1, TP_GRAY=2, TP_SINGLE=3, TP_RAMP=4
//   - the 8-entry 24-bit PALETTE table
//   - FRAME_CNT_W=16
//  Sub-module btn_debounce (sync + stable counter, parameter DEBOUNCE_CYC, output press pulse).
//  FSM, fs detect, frame counter and palette stay in pattern_sched.
// TESTING  (bench: FRAMES_PER_MODE=4, NUM_MODES=5, DEBOUNCE_CYC=16; VS of 20 clk period, 2 clk active)
//  1. Reset with I_auto_en=1, I_vs_pol=1, VS high at release: no fs on the first cycle.
//     O_mode=0 until the 4th fs; then O_mode=1, strobe for 1 clk, O_frame_cnt=0.
//  2. Auto for 20 frames: O_mode 0,1,2,3,4,0. On the wrap: O_single=FF0000, pal_idx=2.
//  3. I_auto_en=0, bounce I_btn_n (toggling every 3 clk for 30 clk), then hold low:
//     exactly one advance, at the next fs after the stable press. 100 frames with no press: O_mode unchanged.
//  4. Press landing on the cycle the timed expiry fs occurs (auto): O_mode +1 only, pending=0 afterwards.
//  5. I_vs_pol=0 with inverted VS: advances occur on the falling I_vs edge, same counts as test 2.
//  6. Assert I_rst_n mid-frame with pending=1 and O_mode=3: all outputs at reset values next cycle.
//     No advance on the first fs after release.

Source files
------------

// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared types, mode codes and colour palette for the pattern scheduler
// Purpose : scheduler state encoding, testpattern mode codes, the 8-entry
//           single-colour palette and the frame counter width.
// Ports   : none (package)
package pattern_pkg;

  typedef enum logic {
    S_AUTO   = 1'b0,
    S_MANUAL = 1'b1
  } sched_state_e;

  localparam logic [2:0] TP_COLORBAR = 3'd0;
  localparam logic [2:0] TP_NET      = 3'd1;
  localparam logic [2:0] TP_GRAY     = 3'd2;
  localparam logic [2:0] TP_SINGLE   = 3'd3;
  localparam logic [2:0] TP_RAMP     = 3'd4;

  localparam int FRAME_CNT_W = 16;

  // Reset colour (green) is entry 1, so the palette index resets to 1.
  localparam logic [2:0] PAL_RESET_IDX = 3'd1;

  function automatic logic [23:0] palette(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd0:    rgb = 24'h000000;
      3'd1:    rgb = 24'h00FF00;
      3'd2:    rgb = 24'hFF0000;
      3'd3:    rgb = 24'h0000FF;
      3'd4:    rgb = 24'hFFFFFF;
      3'd5:    rgb = 24'hFFFF00;
      3'd6:    rgb = 24'h00FFFF;
      default: rgb = 24'hFF00FF;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser and debouncer producing a one-cycle press pulse
// Purpose : 2-FF synchronise an asynchronous active-low button, accept a new
//           level only after DEBOUNCE_CYC consecutive samples that differ from
//           the stable level, and pulse press_o on the stable 1->0 transition.
// Ports   : clk_i     in  1  clock
//           rst_n_i   in  1  asynchronous active-low reset
//           btn_n_i   in  1  raw active-low button
//           press_o   out 1  registered one-cycle press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 742500
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    // Any sample equal to the stable level restarts the stability window.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_o  <= 1'b0;
    end else begin
      sync1_q  <= btn_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_o  <= press_d;
    end
  end

endmodule

// File: rtl/pattern_sched.sv
// rtl/pattern_sched.sv - frame-synchronous testpattern mode and colour scheduler
// Purpose : steps the testpattern mode every FRAMES_PER_MODE frames (auto) or
//           on a debounced button press, only at frame start, and steps the
//           single-colour palette each time the mode wraps to 0.
// Ports   : I_pxl_clk      in  1   pixel clock
//           I_rst_n        in  1   asynchronous active-low reset
//           I_vs           in  1   vertical sync fed back from testpattern
//           I_vs_pol       in  1   VS polarity, 1 = active high
//           I_auto_en      in  1   auto-advance enable, sampled at frame start
//           I_btn_n        in  1   raw active-low user button
//           O_mode         out 3   pattern mode
//           O_single_r/g/b out 8   single-colour value
//           O_frame_cnt    out 16  frames shown in current mode, saturating
//           O_mode_strobe  out 1   pulse on the cycle mode/colour change
module pattern_sched
  import pattern_pkg::*;
#(
  parameter int FRAMES_PER_MODE = 256,
  parameter int NUM_MODES       = 5,
  parameter int DEBOUNCE_CYC    = 742500
) (
  input  logic                   I_pxl_clk,
  input  logic                   I_rst_n,
  input  logic                   I_vs,
  input  logic                   I_vs_pol,
  input  logic                   I_auto_en,
  input  logic                   I_btn_n,
  output logic [2:0]             O_mode,
  output logic [7:0]             O_single_r,
  output logic [7:0]             O_single_g,
  output logic [7:0]             O_single_b,
  output logic [FRAME_CNT_W-1:0] O_frame_cnt,
  output logic                   O_mode_strobe
);

  localparam logic [FRAME_CNT_W-1:0] CNT_LAST  = FRAME_CNT_W'(FRAMES_PER_MODE - 1);
  localparam logic [2:0]             MODE_LAST = 3'(NUM_MODES - 1);

  sched_state_e state_q;
  logic         vs_a;
  logic         vs_a_q, vs_d1_q;
  logic         fs;
  logic         press;
  logic         pending_q;
  logic [2:0]   pal_idx_q;
  logic [2:0]   pal_idx_nx;
  logic [23:0]  pal_rgb_nx;
  logic         expire;
  logic         advance;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk_i   (I_pxl_clk),
    .rst_n_i (I_rst_n),
    .btn_n_i (I_btn_n),
    .press_o (press)
  );

  // Normalise VS to active-high, then register before edge detection so the
  // raw input never reaches an output combinationally. Both stages reset to 1
  // so a VS already active at reset release is not seen as a frame start.
  assign vs_a = ~(I_vs ^ I_vs_pol);
  assign fs   = vs_a_q & ~vs_d1_q;

  assign expire     = (state_q == S_AUTO) && (O_frame_cnt == CNT_LAST);
  // A press arriving on the frame-start cycle is folded into this advance.
  assign advance    = fs && (expire || pending_q || press);
  assign pal_idx_nx = pal_idx_q + 3'd1;
  assign pal_rgb_nx = palette(pal_idx_nx);

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q       <= S_AUTO;
      vs_a_q        <= 1'b1;
      vs_d1_q       <= 1'b1;
      pending_q     <= 1'b0;
      pal_idx_q     <= PAL_RESET_IDX;
      O_mode        <= TP_COLORBAR;
      O_single_r    <= 8'h00;
      O_single_g    <= 8'hFF;
      O_single_b    <= 8'h00;
      O_frame_cnt   <= '0;
      O_mode_strobe <= 1'b0;
    end else begin
      vs_a_q        <= vs_a;
      vs_d1_q       <= vs_a_q;
      O_mode_strobe <= 1'b0;

      if (press) begin
        pending_q <= 1'b1;
      end

      if (fs) begin
        state_q <= I_auto_en ? S_AUTO : S_MANUAL;
      end

      if (advance) begin
        pending_q     <= 1'b0;
        O_frame_cnt   <= '0;
        O_mode_strobe <= 1'b1;
        if (O_mode == MODE_LAST) begin
          O_mode     <= 3'd0;
          pal_idx_q  <= pal_idx_nx;
          O_single_r <= pal_rgb_nx[23:16];
          O_single_g <= pal_rgb_nx[15:8];
          O_single_b <= pal_rgb_nx[7:0];
        end else begin
          O_mode <= O_mode + 3'd1;
        end
      end else if (fs && (O_frame_cnt != '1)) begin
        O_frame_cnt <= O_frame_cnt + 1'b1;
      end
    end
  end

endmodule
